serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 15 +
 rtl/fs_digit.sv | 15 +
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM encoding and
// parameter legality check used at elaboration.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && (width % digit == 0);
  endfunction

endpackage

// File: rtl/fs_digit.sv
// DIGIT-bit full subtractor: {bo, diff} = a - b - bin, unsigned.
module fs_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bo
);

  // The extra MSB goes negative exactly when a < b + bin.
  assign {bo, diff} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: consumes DIGIT bits of a/b per cycle, LSB first,
// and publishes diff/bo with a one-cycle done pulse when the last digit lands.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_param
    $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t             state, state_n;
  logic [WIDTH-1:0]   sa, sb;
  logic               brw;
  logic [CW-1:0]      cnt;
  logic [DIGIT-1:0]   dd;
  logic               dbo;
  logic               last;
  logic               accept;
  logic [WIDTH-1:0]   part_nxt;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(NDIG - 1));

  fs_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (sa[DIGIT-1:0]),
    .b    (sb[DIGIT-1:0]),
    .bin  (brw),
    .diff (dd),
    .bo   (dbo)
  );

  // Partial result fills from the top; after NDIG shifts digit 0 sits at the LSB.
  if (NDIG > 1) begin : g_part
    logic [WIDTH-DIGIT-1:0] part;
    assign part_nxt = {dd, part};
    always_ff @(posedge clk) begin
      if (rst)                 part <= '0;
      else if (accept)         part <= '0;
      else if (state == RUN)   part <= part_nxt[WIDTH-1:DIGIT];
    end
  end else begin : g_single
    assign part_nxt = dd;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bo   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state == RUN) && last;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        brw <= bin;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> DIGIT;
        sb  <= sb >> DIGIT;
        brw <= dbo;
        cnt <= cnt + CW'(1);
        if (last) begin
          diff <= part_nxt;
          bo   <= dbo;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: directed checks on an 8x1 instance plus randomized runs
// over WIDTH {4,8,16} x DIGIT {1,2,4}.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start, bin;
  logic [7:0] a, b, diff;
  logic       bo, busy, done;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  logic [8:0] last_exp;
  logic [8:0] rnd_fin = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bo(bo), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every done must retire exactly one queued request.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("done_no_req", 32'(done), 32'(0));
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e[7:0]));
        chk("bo", 32'(bo), 32'(e[8]));
      end
    end
  end

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input bit inject);
    logic [8:0] e;
    int k;
    e = {1'b0, ia} - {1'b0, ib} - 9'(ibin);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    q.push_back(e);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'(1));
    k = 0;
    while (!done && k < 20) begin
      chk("hold_diff", 32'(diff), 32'(last_exp[7:0]));
      chk("hold_bo", 32'(bo), 32'(last_exp[8]));
      if (inject && k == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end else start = 1'b0;
      @(posedge clk); k++; @(negedge clk);
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(8));
    last_exp = e;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_bo", 32'(bo), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    start = 1'b1; a = 8'hAA; @(negedge clk);
    chk("rst_overrides_start", 32'(busy), 32'(0));
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, 0);
    do_op(8'h00, 8'h01, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);
    do_op(8'h42, 8'h42, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);

    repeat (4) begin
      @(negedge clk);
      chk("idle_hold_busy", 32'(busy), 32'(0));
      chk("idle_hold_diff", 32'(diff), 32'(last_exp[7:0]));
    end

    do_op(8'h5A, 8'h3C, 1'b0, 1);
    repeat (12) begin
      @(negedge clk);
      chk("no_requeue", 32'(busy), 32'(0));
    end
    chk("queue_empty", 32'(q.size()), 32'(0));

    // Abort in the 4th RUN cycle; no request is queued for it.
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_diff", 32'(diff), 32'(0));
    chk("abort_bo", 32'(bo), 32'(0));
    last_exp = '0;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    do_op(8'h5A, 8'h3C, 1'b0, 0);

    for (int t = 0; t < 5000 && rnd_fin != 9'h1FF; t++) @(negedge clk);
    chk("rnd_complete", 32'(rnd_fin), 32'(9'h1FF));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_rnd
    localparam int W  = (gi < 3) ? 4 : (gi < 6) ? 8 : 16;
    localparam int D  = (gi % 3 == 0) ? 1 : (gi % 3 == 1) ? 2 : 4;
    localparam int ND = W / D;

    logic         r_rst, r_start, r_bin, r_bo, r_busy, r_done;
    logic [W-1:0] r_a, r_b, r_diff;
    logic [W:0]   rq[$];

    serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(r_rst), .start(r_start), .a(r_a), .b(r_b), .bin(r_bin),
      .diff(r_diff), .bo(r_bo), .busy(r_busy), .done(r_done)
    );

    initial begin
      logic [W:0] e;
      int k;
      r_rst = 1'b1; r_start = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0;
      repeat (2) @(negedge clk);
      r_rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
        r_a = W'($urandom); r_b = W'($urandom); r_bin = 1'($urandom);
        if (W == 8 && D == 4 && i == 0) begin
          r_a = W'(32'h80); r_b = W'(32'h01); r_bin = 1'b0;
        end
        rq.push_back({1'b0, r_a} - {1'b0, r_b} - (W+1)'(r_bin));
        r_start = 1'b1;
        @(posedge clk); @(negedge clk);
        r_start = 1'b0;
        k = 0;
        while (!r_done && k < ND + 5) begin
          @(posedge clk); k++; @(negedge clk);
        end
        chk("rnd_latency", 32'(k), 32'(ND));
        if (r_done) begin
          e = rq.pop_front();
          chk("rnd_diff", 32'(r_diff), 32'(e[W-1:0]));
          chk("rnd_bo", 32'(r_bo), 32'(e[W]));
        end
        @(negedge clk);
      end
      rnd_fin[gi] = 1'b1;
    end
  end

endmodule
